// File: rtl/ee354_gcd_pkg.sv
// Shared types and constants for the ee354_GCD operand sequencer.
package ee354_gcd_pkg;

   localparam int W_DEF = 8;
   localparam int CYC_W = 8;
   localparam logic [CYC_W-1:0] CYC_SAT = 8'd255;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_ACK    = 3'd3,
      S_OUT    = 3'd4
   } state_e;

   function automatic logic [CYC_W-1:0] cyc_sat_inc(input logic [CYC_W-1:0] c);
      return (c == CYC_SAT) ? c : c + 1'b1;
   endfunction

endpackage

// File: rtl/ee354_gcd_opfifo.sv
// Operand-pair FIFO with clock enable; pointers wrap naturally since DEPTH is a power of two.
module ee354_gcd_opfifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 16
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          CEN,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   // A push on a full FIFO is refused even when a pop happens the same cycle.
   assign do_push = CEN & push_i & ~full_o;
   assign do_pop  = CEN & pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ee354_gcd_sequencer.sv
// Front end for the ee354_GCD core: queues operand pairs, runs one job at a time, returns results.
// Optional watchdog enabled by defining GCD_SEQ_TIMEOUT_EN.
module ee354_gcd_sequencer
   import ee354_gcd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = W_DEF
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             CEN,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [W-1:0]     In_A,
   input  logic [W-1:0]     In_B,
   output logic [W-1:0]     Gcd_Ain,
   output logic [W-1:0]     Gcd_Bin,
   output logic             Gcd_Start,
   output logic             Gcd_Ack,
   input  logic             Gcd_q_Sub,
   input  logic             Gcd_q_Done,
   input  logic [W-1:0]     Gcd_Result,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [W-1:0]     Out_A,
   output logic [W-1:0]     Out_B,
   output logic [W-1:0]     Out_Gcd,
   output logic [CYC_W-1:0] Out_Cycles,
   output logic             Out_Err,
   output logic             Busy
);
   localparam int PW = 2 * W;

   state_e           state_q;
   logic [W-1:0]     op_a_q, op_b_q, res_q;
   logic [CYC_W-1:0] cyc_q;
   logic             start_q, ack_q, out_valid_q, busy_q, sub_seen_q;
   logic             fifo_full, fifo_empty;
   logic [PW-1:0]    fifo_rdata;
   logic [W-1:0]     head_a, head_b;
`ifdef GCD_SEQ_TIMEOUT_EN
   logic             err_q;
   logic [CYC_W-1:0] wd_q;
`endif

   ee354_gcd_opfifo #(.DEPTH(DEPTH), .DW(PW)) u_opfifo (
      .Clk     (Clk),
      .Reset   (Reset),
      .CEN     (CEN),
      .push_i  (In_Valid),
      .wdata_i ({In_A, In_B}),
      .pop_i   (state_q == S_IDLE),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_a = fifo_rdata[PW-1:W];
   assign head_b = fifo_rdata[W-1:0];

   assign In_Ready   = ~fifo_full;
   assign Gcd_Ain    = op_a_q;
   assign Gcd_Bin    = op_b_q;
   assign Gcd_Start  = start_q;
   assign Gcd_Ack    = ack_q;
   assign Out_Valid  = out_valid_q;
   assign Out_A      = op_a_q;
   assign Out_B      = op_b_q;
   assign Out_Gcd    = res_q;
   assign Out_Cycles = cyc_q;
   assign Busy       = busy_q;
`ifdef GCD_SEQ_TIMEOUT_EN
   assign Out_Err    = err_q;
`else
   assign Out_Err    = 1'b0;
`endif

   // Every register is gated by CEN, so a pulse held across disabled cycles completes on the next enabled edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         res_q       <= '0;
         cyc_q       <= '0;
         start_q     <= 1'b0;
         ack_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         sub_seen_q  <= 1'b0;
`ifdef GCD_SEQ_TIMEOUT_EN
         err_q       <= 1'b0;
         wd_q        <= '0;
`endif
      end else if (CEN) begin
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  op_a_q <= head_a;
                  op_b_q <= head_b;
                  cyc_q  <= '0;
                  busy_q <= 1'b1;
`ifdef GCD_SEQ_TIMEOUT_EN
                  err_q  <= 1'b0;
`endif
                  // A zero operand needs no core run: gcd(0,x) = x.
                  if (head_a == '0 || head_b == '0) begin
                     res_q       <= (head_a == '0) ? head_b : head_a;
                     out_valid_q <= 1'b1;
                     state_q     <= S_OUT;
                  end else begin
                     start_q <= 1'b1;
                     state_q <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               start_q    <= 1'b0;
               cyc_q      <= '0;
               sub_seen_q <= 1'b0;
`ifdef GCD_SEQ_TIMEOUT_EN
               wd_q       <= '0;
`endif
               state_q    <= S_WAIT;
            end
            S_WAIT: begin
               if (Gcd_q_Sub || sub_seen_q) cyc_q <= cyc_sat_inc(cyc_q);
               if (Gcd_q_Sub) sub_seen_q <= 1'b1;
               if (Gcd_q_Done) begin
                  res_q   <= Gcd_Result;
                  ack_q   <= 1'b1;
                  state_q <= S_ACK;
               end
`ifdef GCD_SEQ_TIMEOUT_EN
               else if (wd_q == CYC_SAT - 1'b1) begin
                  res_q   <= '0;
                  cyc_q   <= CYC_SAT;
                  err_q   <= 1'b1;
                  ack_q   <= 1'b1;
                  state_q <= S_ACK;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
`endif
            end
            S_ACK: begin
               ack_q       <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= S_OUT;
            end
            S_OUT: begin
               if (Out_Ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               start_q     <= 1'b0;
               ack_q       <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
